// File: rtl/alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_exec_unit: multi-cycle ALU with valid/ready in/out and iterative     |
// | shifts. Optional macro ALU_EXEC_BARREL_SHIFT_EN selects a barrel shifter.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   comb_result;
  logic [WIDTH-1:0]   load_val;
  logic               load;

  assign shamt = SrcB[SHAMT_W-1:0];

  // Single-cycle result for every opcode; shifts here are full barrel shifts,
  // used directly in the barrel build and for shamt=0 in the iterative build.
  always_comb begin
    comb_result = '0;
    case (ALUControl)
      OP_ADD: comb_result = SrcA + SrcB;
      OP_SUB: comb_result = SrcA - SrcB;
      OP_AND: comb_result = SrcA & SrcB;
      OP_OR:  comb_result = SrcA | SrcB;
      OP_SLL: comb_result = SrcA << shamt;
      OP_SLT: comb_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SRL: comb_result = SrcA >> shamt;
      OP_SRA: comb_result = $unsigned($signed(SrcA) >>> shamt);
      default: comb_result = '0;
    endcase
  end

`ifndef ALU_EXEC_BARREL_SHIFT_EN
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] count_q;
  logic [WIDTH-1:0]   step;
  logic               is_shift;
  logic               start_shift;

  assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                    (ALUControl == OP_SRA);

  always_comb begin
    step = work_q >> 1;
    case (op_q)
      OP_SLL:  step = work_q << 1;
      OP_SRA:  step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: step = work_q >> 1;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_val   = comb_result;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
    start_shift = 1'b0;
`endif
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
`ifndef ALU_EXEC_BARREL_SHIFT_EN
          if (is_shift && (shamt != '0)) begin
            start_shift = 1'b1;
            state_next  = SHIFT;
          end else begin
            load       = 1'b1;
            state_next = DONE;
          end
`else
          load       = 1'b1;
          state_next = DONE;
`endif
        end
      end
`ifndef ALU_EXEC_BARREL_SHIFT_EN
      SHIFT: begin
        // The last step is the one that takes the count from 1 to 0.
        if (count_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
          load       = 1'b1;
          load_val   = step;
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        busy       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else if (load) begin
      ALUResult <= load_val;
      Zero      <= (load_val == '0);
    end
  end

`ifndef ALU_EXEC_BARREL_SHIFT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_ADD;
      work_q  <= '0;
      count_q <= '0;
    end else if (start_shift) begin
      op_q    <= ALUControl;
      work_q  <= SrcA;
      count_q <= shamt;
    end else if (state == SHIFT) begin
      work_q  <= step;
      count_q <= count_q - 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops
// against an arithmetic reference model. Honors ALU_EXEC_BARREL_SHIFT_EN.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned sh;
    longint      sa;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a * (32'd1 << sh);
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd6: return a / (32'd1 << sh);
      default: begin
        sa = longint'(int'(a));
        // Floor division by 2^sh reproduces arithmetic right shift.
        if (sa < 0) sa = -((-sa + (64'sd1 << sh) - 1) / (64'sd1 << sh));
        else        sa = sa / (64'sd1 << sh);
        return sa[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    if (BARREL) return 1;
    if ((op == 3'd4 || op == 3'd6 || op == 3'd7) && sh != 0) return 1 + int'(sh);
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          lat;
    int          waitc;
    bit          bad;
    exp   = model(op, a, b);
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      tick();
      waitc++;
    end
    ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; ALUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 1;
    bad = 1'b0;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) bad = 1'b1;
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(op, b)));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      if (in_ready || !out_valid || !busy || ALUResult !== exp) bad = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check({tag, "_res"}, ALUResult, exp);
    check({tag, "_zero"}, {31'd0, Zero}, {31'd0, exp == 32'd0});
    check({tag, "_flow"}, {31'd0, bad}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ret"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    logic [31:0] held;
    logic        held_z;
    bit          bad;
    bit          rose;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUControl = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    run_op("add_wrap", 3'd0, 32'h7FFF_FFFF, 32'd1, 0);
    run_op("sub_zero", 3'd1, 32'd5, 32'd5, 0);
    run_op("slt_neg", 3'd5, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("slt_pos", 3'd5, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("or_bytes", 3'd3, 32'h0000_00F0, 32'h0000_000F, 0);
    run_op("sra4", 3'd7, 32'h8000_0000, 32'd4, 0);
    run_op("srl4", 3'd6, 32'h8000_0000, 32'd4, 0);
    run_op("sll31", 3'd4, 32'd1, 32'd31, 0);
    run_op("sra_sh0", 3'd7, 32'h8123_4567, 32'd32, 0);

    // Backpressure: result held while new requests are offered.
    ALUControl = 3'd2; SrcA = 32'hF0F0_1234; SrcB = 32'hFF00_FF00; in_valid = 1'b1;
    tick();
    held = ALUResult; held_z = Zero;
    check("bp_first", held, 32'hF000_1200);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ALUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom; in_valid = 1'b1;
      tick();
      if (ALUResult !== held || Zero !== held_z || !out_valid || in_ready) bad = 1'b1;
    end
    check("bp_stable", {31'd0, bad}, 32'd0);
    ALUControl = 3'd0; SrcA = 32'd100; SrcB = 32'd23; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle", {30'd0, in_ready, out_valid}, 32'b10);
    tick();
    in_valid = 1'b0;
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_res", ALUResult, 32'd123);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the third cycle of a long shift.
    ALUControl = 3'd4; SrcA = 32'd1; SrcB = 32'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rose = out_valid;
    tick();
    rose |= out_valid;
    tick();
    rose |= out_valid;
    #2 reset = 1'b1;
    #1;
    check("abort_rose", {31'd0, rose}, {31'd0, BARREL});
    check("abort_outs", {28'd0, in_ready, out_valid, Zero, busy}, 32'b1010);
    check("abort_result", ALUResult, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("abort_idle", {30'd0, in_ready, out_valid}, 32'b10);
    run_op("post_abort_add", 3'd0, 32'd40, 32'd2, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
